// File: rtl/led_decoder_3to8.sv
// Registered 3-to-8 line decoder driving an active-low LED bank.
// One LED is lit per the select value when the three-line enable matches its active pattern.
module led_decoder_3to8 #(
  parameter int                SEL_W      = 3,
  parameter int                OUT_W      = 8,
  parameter int                EN_W       = 3,
  parameter logic [EN_W-1:0]   EN_ACTIVE  = 3'b100,
  parameter logic [OUT_W-1:0]  IDLE_VALUE = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EN_W-1:0]  enable,
  input  logic [SEL_W-1:0] switch,
  output logic [OUT_W-1:0] led
);

  localparam logic [OUT_W-1:0] ONE_HOT_LSB = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [OUT_W-1:0] led_d;
  logic [OUT_W-1:0] led_q;

  // Next-state decode: clear exactly the selected bit only for the active enable pattern.
  always_comb begin
    led_d = IDLE_VALUE;
    if (enable == EN_ACTIVE) begin
      led_d = IDLE_VALUE & ~(ONE_HOT_LSB << switch);
    end else begin
      led_d = IDLE_VALUE;
    end
  end

  // Output register; reset darkens the bank without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= IDLE_VALUE;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_decoder_3to8.sv
// Scoreboard bench for led_decoder_3to8: the driver queues the expected LED pattern,
// a monitor pops and compares one entry after every rising clock edge.
module tb_led_decoder_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [7:0] led;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  led_decoder_3to8 dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the lit LED is the power-of-two weight removed from an all-dark 255.
  function automatic logic [7:0] ref_model(input logic r, input logic [2:0] en, input logic [2:0] sw);
    int v;
    v = 255;
    if (r && en == 3'b100) v = 255 - (2 ** int'(sw));
    return 8'(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (!$isunknown(act) && act === req) n_pass++;
    else $display("FAIL %s: led=%h expected=%h at %0t", name, act, req, $time);
  endtask

  // Drive inputs away from the sampling edge and queue what the next rising edge must produce.
  task automatic step(input logic [2:0] en, input logic [2:0] sw, input logic r);
    @(negedge clk);
    enable = en;
    switch = sw;
    rst    = r;
    exp_q.push_back(ref_model(r, en, sw));
  endtask

  // Monitor: every rising edge, shortly after, retire one queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("scoreboard", led, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] en_list[7];

  initial begin
    en_list = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1'b1; enable = 3'b100; switch = 3'd3;
    #1 rst = 1'b0;
    #1 check("async_reset_no_clock", led, 8'hFF);

    // Held in reset across several edges, then release.
    for (int i = 0; i < 3; i++) step(3'b100, 3'd3, 1'b0);
    step(3'b100, 3'd3, 1'b1);
    #1 check("release_no_change", led, 8'hFF);

    // Full decode sweep.
    for (int i = 0; i < 8; i++) step(3'b100, 3'(i), 1'b1);

    // Enable gating, then re-enable.
    for (int i = 0; i < 7; i++) step(en_list[i], 3'd5, 1'b1);
    step(3'b100, 3'd5, 1'b1);

    // Async reset between edges.
    step(3'b100, 3'd7, 1'b1);
    @(posedge clk); #3;
    check("pre_async_7F", led, 8'h7F);
    rst = 1'b0;
    #1 check("async_mid_run", led, 8'hFF);

    // Mid-cycle input changes must wait for the next edge.
    step(3'b100, 3'd2, 1'b1);
    @(posedge clk); #2;
    switch = 3'd6;
    #1 check("hold_until_edge", led, 8'hFB);
    step(3'b100, 3'd6, 1'b1);
    @(posedge clk); #2;
    enable = 3'b000;
    #1 enable = 3'b100;
    #1 check("enable_glitch", led, 8'hBF);
    step(3'b100, 3'd6, 1'b1);

    // Random regression.
    for (int i = 0; i < 80; i++) begin
      logic       r;
      logic [2:0] en;
      r  = ($urandom_range(0, 9) != 0);
      en = ($urandom_range(0, 3) != 0) ? 3'b100 : 3'($urandom_range(0, 7));
      step(en, 3'($urandom_range(0, 7)), r);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #3;
        rst = 1'b0;
        #1 check("random_async_reset", led, 8'hFF);
      end
    end

    step(3'b100, 3'd0, 1'b1);
    @(posedge clk); @(posedge clk); #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: pending=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
